// File: rtl/tx_pkg.sv
// Shared types and default parameters for the transmit shift controller.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EOP   = 2'd2
    } tx_state_t;

    localparam int NUM_BITS_DEF     = 8;
    localparam int CLKS_PER_BIT_DEF = 8;
    localparam int EOP_BITS_DEF     = 2;

endpackage

// File: rtl/tx_bit_timer.sv
// Wrap counter 0..TERM-1 with enable and clear; tick marks the enabled
// terminal-count cycle so the caller can act on the wrap in that same cycle.
module tx_bit_timer #(
    parameter int TERM  = 8,
    parameter int WIDTH = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERM - 1);

    logic [WIDTH-1:0] count_reg;

    assign tick = en && (count_reg == LAST);

    // Count register: clear has priority, wrap to zero on terminal count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tick ? '0 : count_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tx_shift_ctrl.sv
// Transmit controller feeding a parallel-to-serial shift register.
// Accepts words over valid/ready, paces load/shift at CLKS_PER_BIT clocks
// per bit, appends an idle-high end-of-packet interval and flags underruns.
// Optional feature macro: TX_STALL_EN adds a tx_stall input that freezes
// the active packet timing.
module tx_shift_ctrl
    import tx_pkg::*;
#(
    parameter int NUM_BITS     = NUM_BITS_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int EOP_BITS     = EOP_BITS_DEF
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tx_valid,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_last,
`ifdef TX_STALL_EN
    input  logic                tx_stall,
`endif
    output logic                tx_ready,
    output logic                load_enable,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                tx_active,
    output logic                eop,
    output logic                tx_done,
    output logic                underrun_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W   = $clog2(NUM_BITS);
    localparam int EOPC_W  = $clog2(EOP_BITS + 1);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);

    tx_state_t        state_reg;
    tx_state_t        state_next;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic             last_reg;
    logic             run;
    logic             bit_tick;
    logic             eop_tick;

`ifdef TX_STALL_EN
    assign run = !tx_stall;
`else
    assign run = 1'b1;
`endif

    // Bit-period timer: held at zero while idle, frozen while stalled.
    tx_bit_timer #(
        .TERM  (CLKS_PER_BIT),
        .WIDTH (TIMER_W)
    ) u_bit_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .en    ((state_reg != IDLE) && run),
        .clr   (state_reg == IDLE),
        .tick  (bit_tick)
    );

    // End-of-packet length in bit periods, advanced by each bit-timer wrap.
    tx_bit_timer #(
        .TERM  (EOP_BITS),
        .WIDTH (EOPC_W)
    ) u_eop_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .en    ((state_reg == EOP) && bit_tick),
        .clr   (state_reg != EOP),
        .tick  (eop_tick)
    );

    // The shift register samples tx_data directly when load_enable is high.
    assign parallel_out = tx_data;
    assign eop          = (state_reg == EOP);
    assign tx_active    = (state_reg != IDLE);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bit counter within the current word and the captured last-word flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_reg <= '0;
            last_reg    <= 1'b0;
        end else begin
            if (state_reg != SHIFT) begin
                bit_cnt_reg <= '0;
            end else if (bit_tick) begin
                bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + BIT_W'(1);
            end
            if (load_enable) begin
                last_reg <= tx_last;
            end
        end
    end

    // Next state and strobes; a word boundary either reloads, ends the
    // packet, or reports starvation and drops back to idle.
    always_comb begin
        state_next   = state_reg;
        tx_ready     = 1'b0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        underrun_err = 1'b0;
        tx_done      = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    load_enable = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt_reg != LAST_BIT) begin
                        shift_enable = 1'b1;
                    end else if (last_reg) begin
                        shift_enable = 1'b1;
                        state_next   = EOP;
                    end else begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            load_enable = 1'b1;
                        end else begin
                            shift_enable = 1'b1;
                            underrun_err = 1'b1;
                            state_next   = IDLE;
                        end
                    end
                end
            end
            EOP: begin
                if (eop_tick) begin
                    tx_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/tx_shift_ctrl.md
Name: tx_shift_ctrl

Overview:
- Transmit-side controller that sits directly upstream of the flexible parallel-to-serial shift register.
- Accepts bytes from a packet source over a valid/ready handshake and drives the shift register's parallel data, load enable and shift enable at a fixed bit rate.
- Sequences back-to-back bytes, then an idle-high end-of-packet interval, and flags underruns.
- The shift register idles at '1' and shifts in '1's; this block relies on that for idle and EOP line level.

Parameters:
- NUM_BITS, 8: bits per transferred word; must match the shift register width; ≥2.
- CLKS_PER_BIT, 8: clock cycles per serial bit period; ≥2.
- EOP_BITS, 2: bit periods of idle-high line after the last word of a packet; ≥1.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- tx_valid  input  1  source has a word on tx_data/tx_last
- tx_data  input  NUM_BITS  word to send
- tx_last  input  1  word is the final word of the packet
- tx_ready  output  1  block accepts a word this cycle
- load_enable  output  1  to shift register: load parallel_out
- shift_enable  output  1  to shift register: advance one bit
- parallel_out  output  NUM_BITS  to shift register parallel_in
- tx_active  output  1  packet in progress (SHIFT or EOP)
- eop  output  1  high during EOP interval
- tx_done  output  1  one-cycle pulse, last EOP cycle
- underrun_err  output  1  one-cycle pulse on word starvation

Behaviour:
- Reset and clock:
  - Single clock domain.
  - Asynchronous active-low reset on n_rst forces state IDLE, timer=0, bit_cnt=0, last_q=0.
  - Under reset all registered outputs are 0; tx_ready=1 (IDLE).
- FSM states: IDLE, SHIFT, EOP.
- Transfer: a transfer occurs when tx_valid && tx_ready.
  - On a transfer, load_enable=1 combinationally in the same cycle and parallel_out=tx_data (pass-through, zero latency).
  - last_q<=tx_last, timer<=0, bit_cnt<=0, state<=SHIFT.
  - Bit 0 appears on the shift register output the next cycle.
- parallel_out = tx_data at all times (only sampled when load_enable=1).
- tx_ready is 1 in IDLE, and in SHIFT only on the word-boundary cycle (timer==CLKS_PER_BIT-1, bit_cnt==NUM_BITS-1) when last_q==0. It is 0 otherwise.
- SHIFT state:
  - timer counts 0..CLKS_PER_BIT-1 and wraps.
  - On timer==CLKS_PER_BIT-1, bit_cnt increments (wrapping at NUM_BITS-1).
  - shift_enable=1 on every timer wrap, except at a word boundary where a transfer occurs; there load_enable=1 instead.
  - load_enable and shift_enable are never both 1.
- Word boundary:
  - If last_q=1: shift_enable=1, go to EOP.
  - If last_q=0 and transfer: load the next word and stay in SHIFT.
  - If last_q=0 and no transfer: shift_enable=1, underrun_err=1 for that cycle, go to IDLE. No EOP and no tx_done.
- EOP state:
  - eop=1 and tx_active=1 for EOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle, then go to IDLE.
  - tx_ready=0 throughout EOP.
- tx_valid outside accepting cycles is ignored; the source holds it.
- Timer width is $clog2(CLKS_PER_BIT); bit_cnt width is $clog2(NUM_BITS).
  - The EOP count reuses the timer plus a separate $clog2(EOP_BITS+1) bit-period counter.

Optional Feature:
- TX_STALL_EN adds input tx_stall (1 bit).
- With the macro: while tx_stall=1 in SHIFT or EOP, the timer and counters freeze, and load_enable, shift_enable, tx_ready, tx_done and underrun_err are all 0. Stall in IDLE has no effect.
- Without the macro: no port and no stall logic.

Decomposition:
- Package tx_pkg holds:
  - the state enum typedef tx_state_t {IDLE, SHIFT, EOP};
  - localparam defaults for NUM_BITS, CLKS_PER_BIT and EOP_BITS.
- One natural sub-module: tx_bit_timer, a parameterised wrap counter with enable and clear that outputs a tick on its terminal count. Two instances: bit timer and EOP bit-period count.

Test Plan (NUM_BITS=8, CLKS_PER_BIT=4, EOP_BITS=2; transfer at cycle 0):
- Reset with no stimulus -> tx_ready=1; load_enable, shift_enable, tx_active, eop, tx_done and underrun_err all 0.
- Single word 0xA5, tx_last=1 ->
  - load_enable at cycle 0; shift_enable at cycles 4,8,…,32 (8 pulses).
  - Serial out is 1,0,1,0,0,1,0,1 across bit periods (MSB first).
  - eop high cycles 33–40, tx_done at 40, tx_ready=1 at 41.
- Back-to-back 0x12 (last=0) then 0x34 (last=1) held valid ->
  - tx_ready=1 and load_enable=1 at cycle 32, with no shift_enable at 32.
  - 0x34 bit 0 appears at cycle 33; tx_done at 72.
- Underrun: 0x55, tx_last=0, tx_valid low afterward -> shift_enable and underrun_err at cycle 32, IDLE at 33, eop never asserted.
- n_rst pulsed low at cycle 10 mid-word -> all outputs 0 immediately, tx_ready=1, and a new transfer after release restarts timing from cycle 0.
- TX_STALL_EN defined, 0xA5 last=1, tx_stall high cycles 5–8 -> shift_enable pulses shift to 4,12,16,…,36 and tx_done moves to 44.
